// File: rtl/logic_op_arbiter_if.sv
// Request, result and monitor signals of the shared logic-op unit.
// master: requesters + result consumer side; slave: the arbiter.
interface logic_op_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_sel;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_sel;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;

    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;

    modport master (
        output req0_valid, req0_sel, req0_a, req0_b,
        output req1_valid, req1_sel, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data,
        input  grant_cnt0, grant_cnt1
    );

    modport slave (
        input  req0_valid, req0_sel, req0_a, req0_b,
        input  req1_valid, req1_sel, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data,
        output grant_cnt0, grant_cnt1
    );
endinterface

// File: rtl/logic_op_arbiter.sv
// Two-requester round-robin arbiter in front of one XOR/OR/AND unit.
// Single registered result slot with backpressure, saturating grant counters.
//
// state    | meaning
// ---------+---------------------------------------------
// ST_EMPTY | result register empty, rsp_valid = 0
// ST_FULL  | result register holds a result, rsp_valid = 1
module logic_op_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input logic             i_clk,
    input logic             i_rst_n,
    logic_op_arbiter_if.slave bus
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    state_t           state_d;

    // 1 means requester 1 wins a tie
    logic             prio_q;

    logic             free;
    logic             grant0;
    logic             grant1;
    logic             ready0;
    logic             ready1;
    logic             accept;
    logic [1:0]       acc_sel;
    logic [WIDTH-1:0] acc_a;
    logic [WIDTH-1:0] acc_b;
    logic [WIDTH-1:0] op_result;

    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    function automatic logic [WIDTH-1:0] logic_op(
        input logic [1:0]       sel,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        case (sel)
            2'b00:   return a ^ b;
            2'b01:   return a | b;
            2'b10:   return a & b;
            default: return '0;
        endcase
    endfunction

    // Grant selection, handshake readies and the operand mux feeding the unit.
    // Readies are forced low while reset is asserted.
    always_comb begin
        free    = (state_q == ST_EMPTY) | bus.rsp_ready;
        grant0  = bus.req0_valid & (~bus.req1_valid | ~prio_q);
        grant1  = bus.req1_valid & (~bus.req0_valid |  prio_q);
        ready0  = i_rst_n & free & grant0;
        ready1  = i_rst_n & free & grant1;
        accept  = ready0 | ready1;
        acc_sel = grant1 ? bus.req1_sel : bus.req0_sel;
        acc_a   = grant1 ? bus.req1_a   : bus.req0_a;
        acc_b   = grant1 ? bus.req1_b   : bus.req0_b;
        op_result = logic_op(acc_sel, acc_a, acc_b);
    end

    // Result-slot state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Result-slot next state: fill on accept, empty on drain without refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (bus.rsp_ready && !accept) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Result payload: loads only on accept, otherwise holds (including after drain).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
        end else if (accept) begin
            rsp_id_q   <= grant1;
            rsp_data_q <= op_result;
        end
    end

    // Round-robin pointer: after a grant, the other requester wins the next tie.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prio_q <= 1'b0;
        end else if (accept) begin
            prio_q <= grant0;
        end
    end

    // Saturating per-requester grant counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (ready0 && cnt0_q != '1) begin
                cnt0_q <= cnt0_q + CNT_ONE;
            end
            if (ready1 && cnt1_q != '1) begin
                cnt1_q <= cnt1_q + CNT_ONE;
            end
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp_valid  = (state_q == ST_FULL);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.grant_cnt0 = cnt0_q;
    assign bus.grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Bench for logic_op_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_logic_op_arbiter;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;

    logic_op_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    logic_op_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // model state: what the result slot and counters must hold
    bit          m_valid = 0;
    bit          m_id    = 0;
    logic [31:0] m_data  = '0;
    int          m_cnt0  = 0;
    int          m_cnt1  = 0;
    int          m_ptr   = 0;

    function automatic logic [31:0] ref_op(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
        if (sel == 2'd0) return a ^ b;
        if (sel == 2'd1) return a | b;
        if (sel == 2'd2) return a & b;
        return 32'h0;
    endfunction

    // which requester the model expects to be accepted now (-1: none)
    function automatic int m_winner();
        bit slot_free;
        slot_free = !m_valid || bus.rsp_ready;
        if (!rst_n || !slot_free) return -1;
        if (bus.req0_valid && bus.req1_valid) return m_ptr;
        if (bus.req0_valid) return 0;
        if (bus.req1_valid) return 1;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model update
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 0;
            m_id    <= 0;
            m_data  <= '0;
            m_cnt0  <= 0;
            m_cnt1  <= 0;
            m_ptr   <= 0;
        end else begin
            if (m_winner() == 0) begin
                m_valid <= 1;
                m_id    <= 0;
                m_data  <= ref_op(bus.req0_sel, bus.req0_a, bus.req0_b);
                m_cnt0  <= (m_cnt0 < CMAX) ? m_cnt0 + 1 : CMAX;
                m_ptr   <= 1;
            end else if (m_winner() == 1) begin
                m_valid <= 1;
                m_id    <= 1;
                m_data  <= ref_op(bus.req1_sel, bus.req1_a, bus.req1_b);
                m_cnt1  <= (m_cnt1 < CMAX) ? m_cnt1 + 1 : CMAX;
                m_ptr   <= 0;
            end else if (m_valid && bus.rsp_ready) begin
                m_valid <= 0;
            end
        end
    end

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        check("ready0", {31'b0, bus.req0_ready}, {31'b0, m_winner() == 0});
        check("ready1", {31'b0, bus.req1_ready}, {31'b0, m_winner() == 1});
        check("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, m_valid});
        check("rsp_id", {31'b0, bus.rsp_id}, {31'b0, m_id});
        check("rsp_data", bus.rsp_data, m_data);
        check("cnt0", {28'b0, bus.grant_cnt0}, m_cnt0);
        check("cnt1", {28'b0, bus.grant_cnt1}, m_cnt1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input bit v, input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
        bus.req0_valid = v; bus.req0_sel = s; bus.req0_a = a; bus.req0_b = b;
    endtask

    task automatic drive1(input bit v, input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
        bus.req1_valid = v; bus.req1_sel = s; bus.req1_a = a; bus.req1_b = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_ops [3];
        bit acc0;
        bit acc1;
        exp_ops[0] = 32'h0204_0608;
        exp_ops[1] = 32'h1F3F_5F7F;
        exp_ops[2] = 32'h0000_0000;

        rst_n = 1'b0;
        drive0(1, 2'd0, 32'hF0F0_F0F0, 32'hFFFF_0000);
        drive1(0, 2'd0, 0, 0);
        bus.rsp_ready = 1'b1;
        step();
        step();
        @(negedge clk); #1;
        check("reset_ready0", {31'b0, bus.req0_ready}, 32'd0);
        check("reset_valid", {31'b0, bus.rsp_valid}, 32'd0);
        step();
        rst_n = 1'b1;

        // XOR from requester 0
        @(negedge clk); #1;
        check("t1_ready0", {31'b0, bus.req0_ready}, 32'd1);
        step();
        drive0(0, 2'd0, 0, 0);
        @(negedge clk); #1;
        check("t1_valid", {31'b0, bus.rsp_valid}, 32'd1);
        check("t1_id", {31'b0, bus.rsp_id}, 32'd0);
        check("t1_data", bus.rsp_data, 32'h0F0F_F0F0);
        check("t1_cnt0", {28'b0, bus.grant_cnt0}, 32'd1);

        // AND / OR / zero from requester 1
        for (int i = 0; i < 3; i++) begin
            step();
            drive1(1, 2'(i == 0 ? 2 : (i == 1 ? 1 : 3)), 32'h1234_5678, 32'h0F0F_0F0F);
            step();
            drive1(0, 2'd0, 0, 0);
            @(negedge clk); #1;
            check("t4_id", {31'b0, bus.rsp_id}, 32'd1);
            check("t4_data", bus.rsp_data, exp_ops[i]);
        end

        // both valid, drain every cycle: grants alternate starting at 0
        step();
        drive0(1, 2'd1, 32'hA5A5_0000, 32'h0000_5A5A);
        drive1(1, 2'd0, 32'hFFFF_FFFF, 32'h0000_FFFF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check("t2_ready0", {31'b0, bus.req0_ready}, {31'b0, i % 2 == 0});
            check("t2_ready1", {31'b0, bus.req1_ready}, {31'b0, i % 2 == 1});
            step();
        end

        // stall with a held result
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("t3_stall_ready", {30'b0, bus.req1_ready, bus.req0_ready}, 32'd0);
            check("t3_stall_id", {31'b0, bus.rsp_id}, 32'd1);
            check("t3_stall_data", bus.rsp_data, 32'hFFFF_0000);
            step();
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk); #1;
        check("t3_release_ready0", {31'b0, bus.req0_ready}, 32'd1);
        step();
        @(negedge clk); #1;
        check("t3_release_data", bus.rsp_data, 32'hA5A5_5A5A);

        // saturation: 20 grants to requester 0
        drive1(0, 2'd0, 0, 0);
        do_reset();
        for (int i = 0; i < 20; i++) step();
        @(negedge clk); #1;
        check("t5_cnt0", {28'b0, bus.grant_cnt0}, 32'd15);
        check("t5_cnt1", {28'b0, bus.grant_cnt1}, 32'd0);

        // reset while full and stalled
        step();
        drive0(1, 2'd1, 32'h1111_0000, 32'h0000_2222);
        step();
        drive0(0, 2'd0, 0, 0);
        bus.rsp_ready = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("t6_data", bus.rsp_data, 32'd0);
        check("t6_cnt0", {28'b0, bus.grant_cnt0}, 32'd0);
        step();
        drive0(1, 2'd0, 32'h1, 32'h2);
        drive1(1, 2'd0, 32'h3, 32'h4);
        bus.rsp_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("t6_first_ready0", {31'b0, bus.req0_ready}, 32'd1);
        check("t6_first_ready1", {31'b0, bus.req1_ready}, 32'd0);

        // randomized traffic, payload held until accepted
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            acc0 = bus.req0_valid && bus.req0_ready;
            acc1 = bus.req1_valid && bus.req1_ready;
            step();
            if (!bus.req0_valid || acc0)
                drive0($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom);
            if (!bus.req1_valid || acc1)
                drive1($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom);
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
            if (n == 700) do_reset();
        end

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
